// File: rtl/data_mem_responder.sv
// Word-organised data memory answering MEM-stage load/store requests over a
// req/ready handshake, with a programmable number of wait states.
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  Reset_L,
  input  logic                  req,
  input  logic                  wr,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            be,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  busy
);

  localparam int          LANES   = DATA_WIDTH / 8;
  localparam logic [3:0]  WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nx;
  logic [3:0]              cnt, cnt_nx;
  logic                    accept;

  logic                    cap_wr, cap_err;
  logic [ADDR_WIDTH-1:0]   cap_idx;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [3:0]              cap_be;

  logic                    in_err;
  logic                    rsp_wr, rsp_err;
  logic [ADDR_WIDTH-1:0]   rsp_idx;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   fwd;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  assign in_err = (addr[1:0] != 2'b00) || (addr[31:ADDR_WIDTH+2] != '0);
  assign commit = (state == S_RESP) && cap_wr && !cap_err;
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        state_nx = S_IDLE;
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nx = S_RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states the responding transaction is the one being accepted
  // now, so its read must see a store committing on this very edge.
  always_comb begin
    rsp_wr  = cap_wr;
    rsp_err = cap_err;
    rsp_idx = cap_idx;
    if (accept) begin
      rsp_wr  = wr;
      rsp_err = in_err;
      rsp_idx = addr[ADDR_WIDTH+1:2];
    end
    fwd = mem[rsp_idx];
    for (int unsigned i = 0; i < LANES; i++) begin
      if (commit && (cap_idx == rsp_idx) && cap_be[i])
        fwd[8*i +: 8] = cap_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_wr    <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      ready     <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        cap_wr    <= wr;
        cap_err   <= in_err;
        cap_idx   <= addr[ADDR_WIDTH+1:2];
        cap_wdata <= wdata;
        cap_be    <= be;
      end
      ready <= (state_nx == S_RESP);
      if (state_nx == S_RESP) begin
        err   <= rsp_err;
        rdata <= (rsp_wr || rsp_err) ? '0 : fwd;
      end else begin
        err   <= 1'b0;
        rdata <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (cap_be[i]) mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

endmodule
